// File: rtl/flash_pkg.sv
// Shared types and constants for the SPI NOR single-byte read path.
package flash_pkg;

  localparam int unsigned CMD_ADDR_BITS = 32;
  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned FLASH_ADDR_W  = 24;
  localparam int unsigned CPU_ADDR_W    = 11;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    STARTUP,
    IDLE,
    SHIFT_OUT,
    SHIFT_IN,
    DONE,
    RELEASE
  } state_e;

  typedef struct packed {
    logic [7:0]              cmd;
    logic [FLASH_ADDR_W-1:0] addr;
  } read_frame_t;

  // Command/address frame; the 24-bit add wraps past the top of flash.
  function automatic read_frame_t read_frame(input logic [FLASH_ADDR_W-1:0] base,
                                             input logic [CPU_ADDR_W-1:0]   addr);
    read_frame_t f;
    f.cmd  = FLASH_CMD_READ;
    f.addr = base + FLASH_ADDR_W'(addr);
    return f;
  endfunction

endpackage

// File: rtl/flash_sclk_div.sv
// SCLK generator: toggles every HALF_PERIOD clk cycles while enabled, parked low otherwise.
module flash_sclk_div #(
  parameter int unsigned HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sclk,
  output logic rise_strobe_c,
  output logic fall_strobe_c
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CNT_W-1:0] cnt;
  logic             term_c;

  assign term_c        = enable && (cnt == CNT_W'(HALF_PERIOD - 1));
  assign rise_strobe_c = term_c && !sclk;
  assign fall_strobe_c = term_c && sclk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (term_c) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/flash_byte_reader.sv
// Serves single-byte CPU program reads from SPI NOR flash using the 0x03 READ command.
module flash_byte_reader
  import flash_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR      = 24'h000000,
  parameter int unsigned HALF_PERIOD    = 1,
  parameter int unsigned STARTUP_CYCLES = 10800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] flashReadAddr,
  input  logic        enableFlash,
  output logic        flashDataReady,
  output logic [7:0]  flashByteRead,
  output logic        flashClk,
  output logic        flashCs,
  output logic        flashMosi,
  input  logic        flashMiso
);

  localparam int unsigned SU_W  = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned BIT_W = $clog2(CMD_ADDR_BITS);

  state_e                   state, state_d;
  logic [SU_W-1:0]          su_cnt, su_cnt_d;
  logic [CMD_ADDR_BITS-1:0] shift_word, shift_d;
  logic [BIT_W-1:0]         bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0]     data_sr, data_d;
  logic                     cs_d, mosi_d, rdy_d;
  logic [DATA_BITS-1:0]     byte_d;
  logic                     start_c, sclk_en_c, rise_c, fall_c;
  read_frame_t              frame_c;

  flash_sclk_div #(.HALF_PERIOD(HALF_PERIOD)) u_sclk_div (
    .clk           (clk),
    .reset         (reset),
    .enable        (sclk_en_c && !flashCs),
    .sclk          (flashClk),
    .rise_strobe_c (rise_c),
    .fall_strobe_c (fall_c)
  );

  assign frame_c = read_frame(BASE_ADDR, flashReadAddr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= STARTUP;
      su_cnt         <= '0;
      shift_word     <= '0;
      bit_cnt        <= '0;
      data_sr        <= '0;
      flashCs        <= 1'b1;
      flashMosi      <= 1'b0;
      flashDataReady <= 1'b0;
      flashByteRead  <= '0;
    end else begin
      state          <= state_d;
      su_cnt         <= su_cnt_d;
      shift_word     <= shift_d;
      bit_cnt        <= bit_cnt_d;
      data_sr        <= data_d;
      flashCs        <= cs_d;
      flashMosi      <= mosi_d;
      flashDataReady <= rdy_d;
      flashByteRead  <= byte_d;
    end
  end

  always_comb begin
    state_d   = state;
    su_cnt_d  = su_cnt;
    shift_d   = shift_word;
    bit_cnt_d = bit_cnt;
    data_d    = data_sr;
    cs_d      = flashCs;
    mosi_d    = flashMosi;
    rdy_d     = flashDataReady;
    byte_d    = flashByteRead;
    start_c   = 1'b0;
    sclk_en_c = 1'b0;

    case (state)
      STARTUP: begin
        // A request already pending at terminal count starts directly, keeping ready low.
        if (su_cnt == SU_W'(STARTUP_CYCLES - 1)) begin
          if (enableFlash) begin
            start_c = 1'b1;
          end else begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end
        end else begin
          su_cnt_d = su_cnt + SU_W'(1);
        end
      end
      IDLE: begin
        if (enableFlash) start_c = 1'b1;
      end
      SHIFT_OUT: begin
        sclk_en_c = 1'b1;
        if (fall_c) begin
          if (bit_cnt == BIT_W'(CMD_ADDR_BITS - 1)) begin
            state_d   = SHIFT_IN;
            bit_cnt_d = '0;
            mosi_d    = 1'b0;
          end else begin
            shift_d   = shift_word << 1;
            mosi_d    = shift_word[CMD_ADDR_BITS-2];
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end
      end
      SHIFT_IN: begin
        sclk_en_c = 1'b1;
        if (rise_c) data_d = {data_sr[DATA_BITS-2:0], flashMiso};
        if (fall_c) begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_d = DONE;
          else                                  bit_cnt_d = bit_cnt + BIT_W'(1);
        end
      end
      DONE: begin
        cs_d    = 1'b1;
        byte_d  = data_sr;
        rdy_d   = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!enableFlash) state_d = IDLE;
      end
      default: state_d = STARTUP;
    endcase

    // Request acceptance: frame the command, drop CS and present the first MOSI bit.
    if (start_c) begin
      shift_d   = frame_c;
      mosi_d    = frame_c.cmd[7];
      bit_cnt_d = '0;
      cs_d      = 1'b0;
      rdy_d     = 1'b0;
      state_d   = SHIFT_OUT;
    end
  end

endmodule

// File: tb/tb_flash_byte_reader.sv
// Randomized bench: three reader instances against an SPI flash model and an address/latency reference.
module tb_flash_byte_reader;

  localparam int          NI = 3;
  localparam int unsigned SU = 20;

  function automatic logic [23:0] base_of(input int g);
    case (g)
      0:       return 24'h000000;
      1:       return 24'h100000;
      default: return 24'hFFFC00;
    endcase
  endfunction

  function automatic int unsigned hp_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  // Flash array contents.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'h11;
      24'h000001: return 8'h22;
      24'h000005: return 8'hA5;
      24'h1007FF: return 8'h3C;
      default:    return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en    [NI];
  logic [10:0] addr  [NI];
  logic        rdy   [NI];
  logic [7:0]  rbyte [NI];
  logic        sclk  [NI];
  logic        cs    [NI];
  logic        mosi  [NI];
  logic        miso  [NI] = '{default: 1'b0};

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      flash_byte_reader #(
        .BASE_ADDR      (base_of(gi)),
        .HALF_PERIOD    (hp_of(gi)),
        .STARTUP_CYCLES (SU)
      ) dut (
        .clk            (clk),
        .reset          (reset),
        .flashReadAddr  (addr[gi]),
        .enableFlash    (en[gi]),
        .flashDataReady (rdy[gi]),
        .flashByteRead  (rbyte[gi]),
        .flashClk       (sclk[gi]),
        .flashCs        (cs[gi]),
        .flashMosi      (mosi[gi]),
        .flashMiso      (miso[gi])
      );
    end
  endgenerate

  // SPI flash model: captures cmd+address on SCLK rises, returns data after falls.
  int          fbits   [NI] = '{default: 0};
  logic [31:0] rx      [NI] = '{default: 32'h0};
  int          rise1   [NI] = '{default: 0};
  int          period  [NI] = '{default: 0};
  int          cs_run  [NI] = '{default: 100};
  logic        prev_cs [NI] = '{default: 1'b1};
  logic        prev_sc [NI] = '{default: 1'b0};
  int          cycle    = 0;
  int          mode_err = 0;
  int          gap_err  = 0;
  logic [7:0]  mb;

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (cs[g] !== 1'b0) begin
        if (sclk[g] !== 1'b0) mode_err++;
        fbits[g] = 0;
        miso[g]  = 1'b0;
        if (cs_run[g] < 1000) cs_run[g]++;
      end else begin
        if (prev_cs[g] === 1'b1 && cs_run[g] < 2) gap_err++;
        cs_run[g] = 0;
        if (sclk[g] && !prev_sc[g]) begin
          if (fbits[g] < 32) rx[g] = {rx[g][30:0], mosi[g]};
          fbits[g]++;
          if (fbits[g] == 1)      rise1[g]  = cycle;
          else if (fbits[g] == 2) period[g] = cycle - rise1[g];
        end else if (!sclk[g] && prev_sc[g] && fbits[g] >= 32 && fbits[g] < 40) begin
          mb      = mem_byte(rx[g][23:0]);
          miso[g] = mb[3'(39 - fbits[g])];
        end
      end
      prev_cs[g] = cs[g];
      prev_sc[g] = sclk[g];
    end
    cycle++;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int g, input int limit, output int t);
    t = 0;
    while (rdy[g] !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
  endtask

  // One CPU read: called at a negedge with the instance idle.
  task automatic do_read(input int g, input logic [10:0] a, input bit drop);
    logic [23:0] fa;
    logic [7:0]  eb;
    int          t;
    int          k;
    int          hp;
    hp = int'(hp_of(g));
    fa = base_of(g) + {13'd0, a};
    eb = mem_byte(fa);
    expect_eq("pre_ready", rdy[g], 1);
    en[g]   = 1'b1;
    addr[g] = a;
    @(negedge clk);
    expect_eq("rdy_fall", rdy[g], 0);
    expect_eq("cs_low", cs[g], 0);
    addr[g] = 11'($urandom);
    t = 1;
    while (rdy[g] !== 1'b1 && t < 80 * hp + 50) begin
      if (drop && t == 40) en[g] = 1'b0;
      @(negedge clk);
      t++;
    end
    expect_eq("rdy_rise_lat", t, 80 * hp + 2);
    expect_eq("byte", rbyte[g], eb);
    expect_eq("cmd_addr", rx[g], {8'h03, fa});
    expect_eq("sclk_period", period[g], 2 * hp);
    if (drop) begin
      @(negedge clk);
    end else begin
      k = $urandom_range(1, 4);
      repeat (k) begin
        @(negedge clk);
        expect_eq("hold_byte", rbyte[g], eb);
        expect_eq("hold_rdy_cs", {rdy[g], cs[g]}, 2'b11);
      end
      en[g] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int t;
    for (int g = 0; g < NI; g++) begin
      en[g]   = 1'b0;
      addr[g] = '0;
    end
    en[0]   = 1'b1;
    addr[0] = 11'd5;
    #2 reset = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      expect_eq("rst_cs", cs[g], 1);
      expect_eq("rst_sclk", sclk[g], 0);
      expect_eq("rst_mosi", mosi[g], 0);
      expect_eq("rst_rdy", rdy[g], 0);
      expect_eq("rst_byte", rbyte[g], 0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Request held from reset: first ready edge carries the data.
    wait_ready(0, int'(SU) + 200, t);
    expect_eq("startup_lat", t, int'(SU) + 81);
    expect_eq("startup_byte", rbyte[0], 8'hA5);
    expect_eq("startup_cmd", rx[0], 32'h0300_0005);
    expect_eq("idle_rdy_1", rdy[1], 1);
    expect_eq("idle_rdy_2", rdy[2], 1);
    en[0] = 1'b0;
    @(negedge clk);

    do_read(0, 11'd0, 1'b0);
    do_read(0, 11'd1, 1'b0);
    do_read(1, 11'h7FF, 1'b0);
    do_read(2, 11'h7FF, 1'b0);
    do_read(1, 11'h2A5, 1'b1);
    do_read(2, 11'h400, 1'b1);
    for (int i = 0; i < 30; i++)
      do_read($urandom_range(0, NI - 1), 11'($urandom), 1'($urandom_range(0, 1)));
    do_read(0, 11'd5, 1'b0);

    // Reset mid-transfer aborts without touching the result register.
    en[0]   = 1'b1;
    addr[0] = 11'h123;
    t = 0;
    while (fbits[0] < 20 && t < 500) begin
      @(negedge clk);
      t++;
    end
    expect_eq("reach_bit20", 32'(fbits[0] >= 20), 1);
    #2 reset = 1'b0;
    #1;
    expect_eq("abort_cs", cs[0], 1);
    expect_eq("abort_sclk", sclk[0], 0);
    expect_eq("abort_rdy", rdy[0], 0);
    expect_eq("abort_byte", rbyte[0], 0);
    en[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_ready(0, int'(SU) + 10, t);
    expect_eq("restart_lat", t, int'(SU));
    for (int g = 1; g < NI; g++) expect_eq("restart_rdy", rdy[g], 1);

    do_read(0, 11'h123, 1'b0);
    do_read(1, 11'($urandom), 1'b0);
    do_read(2, 11'($urandom), 1'b1);
    do_read(0, 11'($urandom), 1'b1);

    expect_eq("mode0_sclk_idle", mode_err, 0);
    expect_eq("cs_gap", gap_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flash_byte_reader.md
Name: flash_byte_reader

Overview:
- Upstream stage of the CPU: serves single-byte program reads from the external SPI NOR flash.
- Accepts an 11-bit byte address on the enableFlash / flashDataReady handshake the CPU already drives.
- Issues a standard 0x03 READ, shifts one byte in, and holds it on flashByteRead until the CPU releases the request.
- Sits between the CPU and the board flash pins.

Parameters:
BASE_ADDR, 24'h000000, flash byte offset of the program image; the transmitted address is BASE_ADDR + flashReadAddr (24-bit, wraps mod 2^24).
HALF_PERIOD, 1, clk cycles per SCLK half-period (>=1).
STARTUP_CYCLES, 10800, clk cycles held idle after reset before the first access (~400 us at 27 MHz).

Ports:
clk  input  1  system clock (27 MHz)
reset  input  1  asynchronous, active-low reset
flashReadAddr  input  11  byte address, sampled when a request is accepted
enableFlash  input  1  request level; high = read requested
flashDataReady  output  1  high = idle or result valid; low = busy
flashByteRead  output  8  last byte read; stable while flashDataReady=1
flashClk  output  1  SPI SCLK, mode 0
flashCs  output  1  SPI chip select, active-low
flashMosi  output  1  SPI data to flash
flashMiso  input  1  SPI data from flash

Behaviour:
- Reset (reset=0, async): flashClk=0, flashCs=1, flashMosi=0, flashDataReady=0, flashByteRead=0; state=STARTUP; counters cleared. A reset mid-transfer raises flashCs immediately and aborts; no partial data reaches flashByteRead.
- STARTUP: count STARTUP_CYCLES.
  - On terminal count with enableFlash=1: start a transfer directly; flashDataReady stays 0, so a CPU already waiting never sees a spurious ready.
  - On terminal count with enableFlash=0: go to IDLE.
- IDLE: flashDataReady=1.
  - On the edge where enableFlash=1: latch flashReadAddr; build shift word {8'h03, BASE_ADDR+addr}.
  - Same edge: flashDataReady<=0, flashCs<=0, flashMosi<=bit 31; go to SHIFT_OUT.
- SHIFT_OUT: 32 bits, MSB first.
  - flashClk toggles every HALF_PERIOD cycles, starting low.
  - flashMosi changes only after a falling edge (mode 0); the flash samples on the rising edge.
- SHIFT_IN: 8 SCLK periods; flashMiso is sampled on the clk edge that raises flashClk and shifted into a temporary register, MSB first.
- DONE, one cycle after the 40th falling edge:
  - flashCs<=1, flashClk=0.
  - flashByteRead<=shift register; flashDataReady<=1.
  - Go to RELEASE.
- RELEASE: flashDataReady=1, flashByteRead held. Wait for enableFlash=0, then go to IDLE. A new request is never accepted without an intervening enableFlash=0 (one result per request level).
- Latency: flashDataReady falls exactly 1 cycle after the request is accepted. It rises exactly 80*HALF_PERIOD+2 cycles after acceptance (HALF_PERIOD=1 gives 82).
- flashCs minimum high time between transfers: 2 clk cycles (DONE plus at least one IDLE cycle), satisfies tSHSL at 27 MHz.
- enableFlash dropping mid-transfer: the transfer completes, flashDataReady rises, RELEASE exits on the next cycle.
- flashByteRead is changed only in DONE.
- flashReadAddr changes while busy are ignored.
- Address arithmetic is 24-bit. BASE_ADDR+0x7FF crossing 2^24 wraps.

Decomposition:
- Shared package flash_pkg:
  - State enum: STARTUP, IDLE, SHIFT_OUT, SHIFT_IN, DONE, RELEASE.
  - FLASH_CMD_READ=8'h03.
  - CMD_ADDR_BITS=32, DATA_BITS=8, FLASH_ADDR_W=24.
- One sub-module, flash_sclk_div:
  - HALF_PERIOD counter producing flashClk plus single-cycle rise_strobe/fall_strobe.
  - Enabled only while flashCs=0; when disabled it resets to clk low.

Test Plan:
- Flash model preloaded, byte at 0x000005=0xA5, BASE_ADDR=0: after startup, assert enableFlash with addr 5.
  - MOSI stream is 0x03,0x00,0x00,0x05.
  - flashDataReady falls 1 cycle after acceptance, rises 82 cycles after.
  - flashByteRead=0xA5 and holds until enableFlash drops.
- BASE_ADDR=24'h100000, addr 0x7FF, model byte 0x1007FF=0x3C -> address bits sent are 0x1007FF; result 0x3C.
- enableFlash held high from reset -> flashDataReady stays 0 through STARTUP; the transfer starts at terminal count; a single rising ready edge delivers the correct byte.
- Back-to-back requests (addr 0 then 1, bytes 0x11/0x22), CPU-style handshake -> two transfers, flashCs high >=2 cycles between them, results 0x11 then 0x22; enableFlash held high after the first result triggers no second transfer.
- reset asserted at bit 20 of SHIFT_OUT -> flashCs=1 and flashClk=0 asynchronously, flashDataReady=0, flashByteRead=0; after release, a new request reads correctly.
- HALF_PERIOD=3, enableFlash dropped mid-transfer -> SCLK period 6 cycles, ready rises 242 cycles after acceptance, controller returns to IDLE the next cycle.
